// File: rtl/spi_pkg.sv
// Shared types for the generic SPI master: FSM state encoding and SPI mode constants.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   // Modes are encoded as {cpol, cpha}.
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: a down-counter reloaded with the divider value,
// producing a one-cycle tick every i_div+1 cycles while enabled.
module spi_clk_div #(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;

   // While disabled the counter keeps tracking the reload value, so the first
   // enabled cycle already starts a full half-period.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_en || (r_cnt == '0)) begin
         r_cnt <= i_div;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised full-duplex SPI master: configurable width, all four CPOL/CPHA
// modes, programmable SCLK divider and NUM_SS active-low slave selects.
module spi_master_gen
   import spi_pkg::*;
#(
   parameter int  DATA_W = 8,
   parameter int  NUM_SS = 4,
   parameter int  DIV_W  = 8,
   localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic [SEL_W-1:0]  i_ss_sel,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic [DIV_W-1:0]  i_clk_div,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   output logic              o_sclk,
   output logic              o_mosi,
   input  logic              i_miso,
   output logic [NUM_SS-1:0] o_ss_n
);

   localparam int              EDGE_W    = $clog2(2 * DATA_W);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

   spi_state_t        r_state;
   spi_state_t        w_next;
   logic [1:0]        r_mode;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  w_div_load;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_rx_data;
   logic [EDGE_W-1:0] r_edge;
   logic [NUM_SS-1:0] r_ss_n;
   logic [NUM_SS-1:0] w_ss_dec;
   logic              r_sclk;
   logic              r_mosi;
   logic              r_rx_valid;
   logic              w_tick;
   logic              w_cpha;
   logic              w_cpol;
   logic              w_lead;
   logic              w_last;

   assign w_cpha = (r_mode == MODE1) || (r_mode == MODE3);
   assign w_cpol = (r_mode == MODE2) || (r_mode == MODE3);
   assign w_lead = ~r_edge[0];
   assign w_last = (r_edge == LAST_EDGE);

   // The divider must start from the divisor being accepted, not the stale latched one.
   assign w_div_load = (r_state == IDLE) ? i_clk_div : r_div;

   spi_clk_div #(
      .DIV_W(DIV_W)
   ) u_clk_div (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (r_state != IDLE),
      .i_div  (w_div_load),
      .o_tick (w_tick)
   );

   always_comb begin
      w_ss_dec = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
         if (i_ss_sel == SEL_W'(i)) begin
            w_ss_dec[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start)          w_next = SETUP;
         SETUP:   if (w_tick)           w_next = XFER;
         XFER:    if (w_tick && w_last) w_next = HOLD;
         HOLD:    if (w_tick)           w_next = IDLE;
         default:                       w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mode     <= '0;
         r_div      <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_rx_data  <= '0;
         r_edge     <= '0;
         r_ss_n     <= '1;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_sclk <= w_cpol;
               if (i_start) begin
                  r_mode <= {i_cpol, i_cpha};
                  r_div  <= i_clk_div;
                  r_sclk <= i_cpol;
                  r_ss_n <= w_ss_dec;
                  r_edge <= '0;
                  r_rx   <= '0;
                  // For cpha=0 the MSB goes out now, so the register is pre-shifted
                  // and every later drive event just takes the top bit.
                  if (i_cpha) begin
                     r_tx <= i_tx_data;
                  end else begin
                     r_tx   <= i_tx_data << 1;
                     r_mosi <= i_tx_data[DATA_W-1];
                  end
               end
            end
            XFER: begin
               if (w_tick) begin
                  r_sclk <= ~r_sclk;
                  r_edge <= r_edge + 1'b1;
                  if (w_lead != w_cpha) begin
                     r_rx <= {r_rx[DATA_W-2:0], i_miso};
                  end else if (w_cpha || !w_last) begin
                     r_mosi <= r_tx[DATA_W-1];
                     r_tx   <= r_tx << 1;
                  end
               end
            end
            HOLD: begin
               if (w_tick) begin
                  r_ss_n     <= '1;
                  r_rx_data  <= r_rx;
                  r_rx_valid <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_ready    = (r_state == IDLE);
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_sclk     = r_sclk;
   assign o_mosi     = r_mosi;
   assign o_ss_n     = r_ss_n;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench: an 8-bit/4-slave instance with a behavioural SPI slave and
// a 16-bit/3-slave loopback instance, both checked through scoreboard queues.
`timescale 1ns/1ps
module tb_spi_master_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- DUT A: DATA_W=8, NUM_SS=4 ----------------
   logic       a_start = 1'b0;
   logic [7:0] a_tx    = '0;
   logic [1:0] a_sel   = '0;
   logic       a_cpol  = 1'b0;
   logic       a_cpha  = 1'b0;
   logic [7:0] a_div   = '0;
   logic       a_ready, a_rx_valid, a_sclk, a_mosi, a_miso;
   logic [7:0] a_rx;
   logic [3:0] a_ss_n;

   spi_master_gen #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) u_a (
      .i_clk(clk), .i_rst(rst), .i_start(a_start), .o_ready(a_ready),
      .i_tx_data(a_tx), .i_ss_sel(a_sel), .i_cpol(a_cpol), .i_cpha(a_cpha),
      .i_clk_div(a_div), .o_rx_data(a_rx), .o_rx_valid(a_rx_valid),
      .o_sclk(a_sclk), .o_mosi(a_mosi), .i_miso(a_miso), .o_ss_n(a_ss_n));

   // ---------------- DUT B: DATA_W=16, NUM_SS=3, loopback ----------------
   logic        b_start = 1'b0;
   logic [15:0] b_tx    = '0;
   logic [1:0]  b_sel   = '0;
   logic        b_cpol  = 1'b0;
   logic        b_cpha  = 1'b0;
   logic [3:0]  b_div   = '0;
   logic        b_ready, b_rx_valid, b_sclk, b_mosi, b_miso;
   logic [15:0] b_rx;
   logic [2:0]  b_ss_n;

   assign b_miso = b_mosi;

   spi_master_gen #(.DATA_W(16), .NUM_SS(3), .DIV_W(4)) u_b (
      .i_clk(clk), .i_rst(rst), .i_start(b_start), .o_ready(b_ready),
      .i_tx_data(b_tx), .i_ss_sel(b_sel), .i_cpol(b_cpol), .i_cpha(b_cpha),
      .i_clk_div(b_div), .o_rx_data(b_rx), .o_rx_valid(b_rx_valid),
      .o_sclk(b_sclk), .o_mosi(b_mosi), .i_miso(b_miso), .o_ss_n(b_ss_n));

   typedef struct {
      logic [31:0] rx;
      logic [31:0] ss;
      int          busy;
      logic        sclk;
      logic [7:0]  srx;
   } exp_t;

   typedef struct {
      logic       cpol;
      logic       cpha;
      logic [7:0] div;
      logic [1:0] sel;
      logic [7:0] tx;
      bit         loop;
      logic [7:0] slv;
      logic [7:0] exp_rx;
      logic [3:0] exp_ss;
      int         exp_busy;
   } vec_t;

   exp_t qa[$];
   exp_t qb[$];

   // ---------------- behavioural slave on DUT A ----------------
   logic       s_cpol = 1'b0, s_cpha = 1'b0;
   logic [7:0] s_word = '0, s_sh = '0, s_rx = '0;
   logic       s_miso = 1'b0, s_act_q = 1'b0, s_sclk_q = 1'b0;
   bit         loop_a = 1'b1;
   logic       s_act;

   assign s_act  = (a_ss_n != 4'hF) && !rst;
   assign a_miso = loop_a ? a_mosi : s_miso;

   always @(negedge clk) begin
      if (s_act && !s_act_q) begin
         s_sh <= s_word;
         s_rx <= '0;
         if (!s_cpha) s_miso <= s_word[7];
      end else if (s_act && (a_sclk != s_sclk_q)) begin
         if ((a_sclk != s_cpol) != s_cpha) begin
            s_rx <= {s_rx[6:0], a_mosi};
         end else if (s_cpha) begin
            s_miso <= s_sh[7];
            s_sh   <= s_sh << 1;
         end else begin
            s_miso <= s_sh[6];
            s_sh   <= s_sh << 1;
         end
      end
      s_act_q  <= s_act;
      s_sclk_q <= a_sclk;
   end

   // ---------------- monitors / scoreboards ----------------
   int         a_busy = 0, a_done = 0;
   logic [3:0] a_and = '1, a_or = '0;

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst) begin
         a_busy <= 0; a_and <= '1; a_or <= '0;
      end else begin
         if (!a_ready) begin
            a_busy <= a_busy + 1; a_and <= a_and & a_ss_n; a_or <= a_or | a_ss_n;
         end
         if (a_rx_valid) begin
            if (qa.size() == 0) begin
               check("a_spurious_rx_valid", 32'(a_rx_valid), 32'd0);
            end else begin
               e = qa.pop_front();
               check("a_rx_data", 32'(a_rx), e.rx);
               check("a_busy_cycles", 32'(a_busy), 32'(e.busy));
               check("a_ss_n_and", 32'(a_and), e.ss);
               check("a_ss_n_or", 32'(a_or), e.ss);
               check("a_sclk_idle", 32'(a_sclk), 32'(e.sclk));
               check("a_slave_rx", 32'(s_rx), 32'(e.srx));
            end
            a_busy <= 0; a_and <= '1; a_or <= '0; a_done <= a_done + 1;
         end
      end
   end

   int         b_busy = 0, b_done = 0;
   logic [2:0] b_and = '1, b_or = '0;

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst) begin
         b_busy <= 0; b_and <= '1; b_or <= '0;
      end else begin
         if (!b_ready) begin
            b_busy <= b_busy + 1; b_and <= b_and & b_ss_n; b_or <= b_or | b_ss_n;
         end
         if (b_rx_valid) begin
            if (qb.size() == 0) begin
               check("b_spurious_rx_valid", 32'(b_rx_valid), 32'd0);
            end else begin
               e = qb.pop_front();
               check("b_rx_data", 32'(b_rx), e.rx);
               check("b_busy_cycles", 32'(b_busy), 32'(e.busy));
               check("b_ss_n_and", 32'(b_and), e.ss);
               check("b_ss_n_or", 32'(b_or), e.ss);
               check("b_sclk_idle", 32'(b_sclk), 32'(e.sclk));
            end
            b_busy <= 0; b_and <= '1; b_or <= '0; b_done <= b_done + 1;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic wait_ready_a();
      for (int i = 0; i < 2000; i++) begin
         if (a_ready) return;
         @(negedge clk);
      end
      check("a_ready_timeout", 32'(a_ready), 32'd1);
   endtask

   task automatic start_a(input vec_t v);
      wait_ready_a();
      @(negedge clk);
      a_cpol = v.cpol; a_cpha = v.cpha; a_div = v.div; a_sel = v.sel; a_tx = v.tx;
      s_cpol = v.cpol; s_cpha = v.cpha; s_word = v.slv; loop_a = v.loop;
      qa.push_back('{rx: 32'(v.exp_rx), ss: 32'(v.exp_ss), busy: v.exp_busy,
                     sclk: v.cpol, srx: v.tx});
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic wait_done_a(input int target);
      for (int i = 0; (i < 3000) && (a_done < target); i++) @(negedge clk);
      @(negedge clk);
      if (a_done < target) begin
         checks++; errors++;
         $display("FAIL a_done_timeout: got %0d completions expected %0d", a_done, target);
      end
   endtask

   task automatic run_b(input logic [1:0] sel, input logic cpol, input logic cpha,
                        input logic [3:0] div, input logic [15:0] tx,
                        input logic [2:0] ss, input int busy);
      int d0;
      d0 = b_done;
      @(negedge clk);
      b_sel = sel; b_cpol = cpol; b_cpha = cpha; b_div = div; b_tx = tx;
      qb.push_back('{rx: 32'(tx), ss: 32'(ss), busy: busy, sclk: cpol, srx: 8'h00});
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int i = 0; (i < 3000) && (b_done == d0); i++) @(negedge clk);
      @(negedge clk);
      if (b_done == d0) begin
         checks++; errors++;
         $display("FAIL b_done_timeout: got %0d completions expected %0d", b_done, d0 + 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      vec_t va[5];
      vec_t vm;
      int   d0;
      int   n;
      logic prev;

      va[0] = '{1'b0, 1'b0, 8'd0, 2'd0, 8'h9F, 1'b1, 8'h00, 8'h9F, 4'b1110, 18};
      va[1] = '{1'b1, 1'b1, 8'd3, 2'd2, 8'hA5, 1'b0, 8'hFE, 8'hFE, 4'b1011, 72};
      va[2] = '{1'b0, 1'b1, 8'd1, 2'd1, 8'h3C, 1'b0, 8'hC3, 8'hC3, 4'b1101, 36};
      va[3] = '{1'b1, 1'b0, 8'd2, 2'd3, 8'h3C, 1'b0, 8'hC3, 8'hC3, 4'b0111, 54};
      va[4] = '{1'b0, 1'b1, 8'd0, 2'd0, 8'h81, 1'b1, 8'h00, 8'h81, 4'b1110, 18};

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(a_ready), 32'd1);
      check("rst_ss_n", 32'(a_ss_n), 32'hF);
      check("rst_sclk", 32'(a_sclk), 32'd0);
      check("rst_mosi", 32'(a_mosi), 32'd0);
      check("rst_rx_data", 32'(a_rx), 32'd0);
      check("rst_rx_valid", 32'(a_rx_valid), 32'd0);
      check("rst_b_ss_n", 32'(b_ss_n), 32'h7);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         d0 = a_done;
         start_a(va[i]);
         wait_done_a(d0 + 1);
      end

      // start pulsed mid-transfer with different settings must be ignored
      vm = '{1'b0, 1'b0, 8'd1, 2'd0, 8'h5A, 1'b1, 8'h00, 8'h5A, 4'b1110, 36};
      d0 = a_done;
      start_a(vm);
      repeat (10) @(negedge clk);
      a_tx = 8'h00; a_cpol = 1'b1; a_cpha = 1'b1; a_sel = 2'd1; a_div = 8'd7;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      wait_done_a(d0 + 1);
      repeat (5) @(negedge clk);
      check("a_start_not_queued", 32'(a_ready), 32'd1);
      check("a_single_rx_valid", 32'(a_done), 32'(d0 + 1));

      // reset at edge 5 aborts the transfer
      wait_ready_a();
      @(negedge clk);
      a_cpol = 1'b0; a_cpha = 1'b0; a_div = 8'd0; a_sel = 2'd0; a_tx = 8'hF0; loop_a = 1'b1;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      d0 = a_done;
      n = 0;
      prev = a_sclk;
      for (int i = 0; (i < 200) && (n < 5); i++) begin
         @(negedge clk);
         if (a_sclk != prev) n++;
         prev = a_sclk;
      end
      check("a_edges_before_reset", 32'(n), 32'd5);
      rst = 1'b1;
      #1;
      check("abort_ss_n", 32'(a_ss_n), 32'hF);
      check("abort_sclk", 32'(a_sclk), 32'd0);
      check("abort_ready", 32'(a_ready), 32'd1);
      check("abort_rx_valid", 32'(a_rx_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_no_completion", 32'(a_done), 32'(d0));
      check("abort_rx_data_cleared", 32'(a_rx), 32'd0);

      vm = '{1'b0, 1'b0, 8'd0, 2'd0, 8'h55, 1'b1, 8'h00, 8'h55, 4'b1110, 18};
      start_a(vm);
      wait_done_a(d0 + 1);

      // back-to-back: second start accepted in the cycle ready returns
      vm = '{1'b0, 1'b0, 8'd0, 2'd1, 8'hC6, 1'b1, 8'h00, 8'hC6, 4'b1101, 18};
      d0 = a_done;
      start_a(vm);
      a_start = 1'b1;
      qa.push_back('{rx: 32'h39, ss: 32'hD, busy: 18, sclk: 1'b0, srx: 8'h39});
      for (int i = 0; (i < 200) && !a_ready; i++) @(negedge clk);
      check("b2b_ready_with_rx_valid", 32'(a_rx_valid), 32'd1);
      a_tx = 8'h39;
      @(negedge clk);
      a_start = 1'b0;
      check("b2b_ss_n_reasserted", 32'(a_ss_n), 32'hD);
      wait_done_a(d0 + 2);

      // DUT B: out-of-range select and 16-bit loopback
      run_b(2'd3, 1'b0, 1'b0, 4'd0, 16'hBEEF, 3'b111, 34);
      run_b(2'd1, 1'b1, 1'b1, 4'd1, 16'h1234, 3'b101, 68);

      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
